div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit signed/unsigned divider.
- It is the responder to the EX stage's DIV/DIVU request handshake.
- EX acts as the initiator: it issues operands plus `start_i`, holds them, and stalls the pipeline until `ready_o`.
- The 64-bit result feeds EX's `hi_o`/`lo_o`/`whilo_o` write path: `hi` = remainder, `lo` = quotient.

Parameters:
- None. The width is fixed by `RegBus` (32).

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1)
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request (`DivStart`/`DivStop`); held high by EX until it consumes the result
- `annul_i`  in  1  abort the current division (flush or exception)
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}
- `ready_o`  out  1  result valid (`DivResultReady`/`DivResultNotReady`)

Behaviour:
- Reset:
  - Applies on any edge with `rst`=1, from any state, including mid-operation.
  - Goes to state `DivFree`, with `result_o`=0, `ready_o`=0, iteration counter=0.
- State register is 2 bits: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- `DivFree`:
  - `start_i`=1 and `annul_i`=0 and `opdata2_i`=0 → `DivByZero`.
  - `start_i`=1 and `annul_i`=0 and `opdata2_i`≠0 → `DivOn`.
  - On entering `DivOn`: latch operands, take magnitudes when `signed_div_i`=1 and the operand is negative (two's complement), latch sign flags, clear counter.
  - Otherwise stay in `DivFree`; `ready_o`=0, `result_o`=0.
- `DivByZero`: next edge → `DivEnd` with a working result of 0.
- `DivOn`:
  - `annul_i`=1 → `DivFree`; partial result discarded; `ready_o` stays 0.
  - Otherwise perform one restoring-division step per edge:
    - 65-bit working register {partial remainder, dividend/quotient}.
    - Compare the partial remainder's upper 33 bits against {0, |divisor|}.
    - If ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - Counter increments 0→32. When counter=32 the next edge → `DivEnd`, with these sign fix-ups applied:
    - Quotient is negated if `signed_div_i` and the operand signs differ.
    - Remainder is negated if `signed_div_i` and the dividend is negative.
- `DivEnd`:
  - `ready_o`=1 and `result_o` = final value, both registered.
  - Held while `start_i`=1.
  - `start_i`=0 → `DivFree`, with `ready_o`=0 and `result_o`=0 on that edge.
- Latency, counting edge 1 as the edge that samples `start_i`=1 in `DivFree`:
  - Normal division: `ready_o` is high after edge 34.
  - Divide-by-zero: `ready_o` is high after edge 2.
- Operand or `signed_div_i` changes after acceptance are ignored.
- `start_i` dropping during `DivOn` is ignored; only `annul_i` or `rst` aborts.
- `annul_i` is ignored in `DivFree` (blocks acceptance), `DivByZero` and `DivEnd`.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is natural two's-complement wrap; no trap.
- Divide-by-zero result is architecturally UNPREDICTABLE; 0 is the defined value here.
- Simultaneous `rst` and `start_i`: reset wins.
- EX stall rule: EX holds `stallreq` while `start_i`=1 and `ready_o`=0. This is documented for integration and not enforced here.

Decomposition:
- Shared defines file:
  - `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11
  - `DivResultReady` 1'b1, `DivResultNotReady` 1'b0
  - `DivStart` 1'b1, `DivStop` 1'b0
  - `EXE_DIV_OP`, `EXE_DIVU_OP`
  - Existing `ZeroWord`, `RegBus`, `RstEnable`
- No sub-module. The single subtract/compare step is inline; the block is a single module, `div`.

Test Plan:
- Unsigned 100/7 (`signed_div_i`=0, `start_i` held) → after edge 34, `ready_o`=1, `result_o`=0x00000002_0000000E. Drop `start_i` → next edge `ready_o`=0, `result_o`=0.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → `result_o`=0xFFFFFFFF_FFFFFFFD. Signed 7/−2 → 0x00000001_FFFFFFFD.
- Divide-by-zero 5/0 → `ready_o`=1 after edge 2, `result_o`=0. Overflow 0x80000000/0xFFFFFFFF signed → 0x00000000_80000000 after edge 34.
- Annul: start 1000/3, assert `annul_i` for 1 cycle at edge 10 → `DivFree`, `ready_o` never rises. Then start 9/3 → 0x00000000_00000003 after edge 34 from the new start.
- Reset mid-op: `rst`=1 at edge 20 of a division → `ready_o`=0, `result_o`=0 next edge. A new request after reset completes normally.
- Operand change: alter `opdata1_i`/`opdata2_i` at edge 5 of 100/7 → result still 0x00000002_0000000E.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle divider.
package div_pkg;

  localparam int unsigned REG_BUS = 32;

  localparam logic [REG_BUS-1:0] ZERO_WORD  = '0;
  localparam logic               RST_ENABLE = 1'b1;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // One quotient bit per step; the counter runs 0..DIV_STEPS.
  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [REG_BUS-1:0] neg32(input logic [REG_BUS-1:0] v);
    return ~v + {{(REG_BUS-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response handshake between the EX stage (master) and the divider (slave).
interface div_if;
  import div_pkg::*;

  logic               signed_div_i;
  logic [REG_BUS-1:0] opdata1_i;
  logic [REG_BUS-1:0] opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*REG_BUS-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// result = {remainder, quotient}; operands are captured when a request is accepted.
module div
  import div_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  div_state_e state_q, state_d;

  // work = {partial remainder (64:33), dividend bits being consumed / quotient bits}
  logic [2*REG_BUS:0]   work_q, work_d;
  logic [REG_BUS-1:0]   divisor_q, divisor_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 signed_q, signed_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [2*REG_BUS-1:0] result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 neg_a_in, neg_b_in;
  logic [REG_BUS:0]     trial;
  logic [REG_BUS-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= DIV_FREE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i)
          state_d = (bus.opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON: begin
        if (bus.annul_i)               state_d = DIV_FREE;
        else if (cnt_q == DIV_STEPS)   state_d = DIV_END;
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP)   state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  assign neg_a_in = bus.signed_div_i & bus.opdata1_i[REG_BUS-1];
  assign neg_b_in = bus.signed_div_i & bus.opdata2_i[REG_BUS-1];

  // Borrow out of the 33-bit subtraction means partial remainder < divisor.
  assign trial   = {1'b0, work_q[2*REG_BUS-1:REG_BUS]} - {1'b0, divisor_q};
  assign quo_fix = (signed_q && (neg_a_q ^ neg_b_q)) ? neg32(work_q[REG_BUS-1:0])
                                                      : work_q[REG_BUS-1:0];
  assign rem_fix = (signed_q && neg_a_q) ? neg32(work_q[2*REG_BUS:REG_BUS+1])
                                         : work_q[2*REG_BUS:REG_BUS+1];

  always_comb begin
    work_d    = work_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          cnt_d = '0;
          if (bus.opdata2_i == ZERO_WORD) begin
            work_d = '0;
          end else begin
            signed_d  = bus.signed_div_i;
            neg_a_d   = neg_a_in;
            neg_b_d   = neg_b_in;
            divisor_d = neg_b_in ? neg32(bus.opdata2_i) : bus.opdata2_i;
            work_d    = {ZERO_WORD,
                         neg_a_in ? neg32(bus.opdata1_i) : bus.opdata1_i,
                         1'b0};
          end
        end
      end
      DIV_BY_ZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q == DIV_STEPS) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (trial[REG_BUS])
            work_d = {work_q[2*REG_BUS-1:0], 1'b0};
          else
            work_d = {trial[REG_BUS-1:0], work_q[REG_BUS-1:0], 1'b1};
        end
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      work_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      work_q    <= work_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected {rem,quo} and ready cycle,
// a negedge monitor pops and compares whenever ready_o rises.
module tb_div;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if bus();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: compare on every rising edge of ready_o.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 && prev !== 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_result"}, bus.result_o, e.res);
          check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
        end
      end
      prev = bus.ready_o;
    end
  end

  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic expect_res(input string name, input logic [63:0] res, input int unsigned lat);
    exp_t e;
    e.res  = res;
    e.cyc  = cyc + lat;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready_o !== 1'b1) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Hold start one extra cycle (result must persist), then release it.
  task automatic finish_op(input string name, input logic [63:0] res);
    @(negedge clk);
    check({name, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {res[62:0], 1'b1});
    bus.start_i = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
    check({name, "_drop_result"}, bus.result_o, 64'd0);
  endtask

  task automatic run(input string name, input logic sd, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] res, input int unsigned lat);
    issue(sd, a, b);
    expect_res(name, res, lat);
    wait_ready(name);
    finish_op(name, res);
  endtask

  initial begin
    bit saw;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;

    // 100/7 with an annul pulse while in DivEnd, which must be ignored.
    issue(1'b0, 32'd100, 32'd7);
    expect_res("udiv_100_7", 64'h00000002_0000000E, 34);
    wait_ready("udiv_100_7");
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("end_annul_ignored", {bus.result_o[62:0], bus.ready_o}, {63'h00000002_0000000E, 1'b1});
    finish_op("udiv_100_7", 64'h00000002_0000000E);

    run("sdiv_m7_2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34);
    run("sdiv_7_m2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
    run("udiv_big_2",  1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34);
    run("sdiv_m100_m7",1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34);
    run("udiv_max_16", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 34);
    run("div_by_zero", 1'b0, 32'd5,        32'd0,        64'h0,                 2);
    run("sdiv_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);

    // Operands and sign select change after acceptance (sampled at edge 5).
    issue(1'b0, 32'd100, 32'd7);
    expect_res("opchg", 64'h00000002_0000000E, 34);
    repeat (4) @(negedge clk);
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b1;
    wait_ready("opchg");
    finish_op("opchg", 64'h00000002_0000000E);

    // Annul sampled at edge 10 of 1000/3: no result may appear.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) saw = 1'b1;
    end
    check("annul_no_ready", 64'(saw), 64'd0);
    run("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

    // Reset at edge 20 with start held high; reset wins.
    issue(1'b0, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    @(negedge clk);
    check("rst_with_start", 64'(bus.ready_o), 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    run("after_rst_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
